// File: rtl/gt5230_por_pkg.sv
// Shared definitions for the power-on configuration loader: FSM encoding,
// default timing/address parameters and the configuration word count.
package gt5230_por_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      CLR    = 3'd2,
      READ   = 3'd3,
      NEXT   = 3'd4,
      DONE   = 3'd5
   } por_state_e;

   localparam int          DEF_SETTLE_CYC = 16;
   localparam int          DEF_RD_CYC     = 4;
   localparam logic [15:0] DEF_BASE_ADDR  = 16'hFFF0;
   localparam int          NUM_WORDS      = 4;
   localparam int          WORD_W         = 2;
   localparam int          MAX_RETRY      = 2;
   localparam int          CNT_W          = 16;

   // EEPROM address of a configuration word; wraps modulo 2^16.
   function automatic logic [15:0] word_addr(input logic [15:0] base,
                                             input logic [WORD_W-1:0] idx);
      return base + {{(16-WORD_W){1'b0}}, idx};
   endfunction

endpackage

// File: rtl/por_cfg_module.sv
// Power-on configuration loader: settles, then reads four 32-bit trim words
// from EEPROM. Define POR_ECC_RETRY_EN to re-read a word on ECC error.
module por_cfg_module
   import gt5230_por_pkg::*;
#(
   parameter int          SETTLE_CYC = DEF_SETTLE_CYC,
   parameter int          RD_CYC     = DEF_RD_CYC,
   parameter logic [15:0] BASE_ADDR  = DEF_BASE_ADDR
) (
   input  logic         sys_clk,
   input  logic         sys_rst,
   input  logic [37:0]  ee_rd_data,
   input  logic         ecc_err,
   input  logic         cfg_reload,
   output logic         por_rd_en,
   output logic         por_vs_en,
   output logic [15:0]  por_ee_addr,
   output logic         por_tc_sel,
   output logic         por_clr_dl,
   output logic         por_cfg_done,
   output logic [127:0] cfg_data,
   output logic         cfg_err
);

   por_state_e        state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [WORD_W-1:0] word_idx;
   logic              settle_last;
   logic              read_last;
   logic              retry;
   logic              last_word;

   // Only the trim payload is kept; the upper EEPROM bits carry no configuration.
   logic unused_ee_hi;
   assign unused_ee_hi = ^ee_rd_data[37:32];

   assign settle_last = (state == SETTLE) && (cnt == CNT_W'(SETTLE_CYC - 1));
   assign read_last   = (state == READ)   && (cnt == CNT_W'(RD_CYC - 1));
   assign last_word   = (word_idx == WORD_W'(NUM_WORDS - 1));

`ifdef POR_ECC_RETRY_EN
   logic [1:0] retry_cnt;
   assign retry = read_last && ecc_err && (retry_cnt < 2'(MAX_RETRY));
`else
   assign retry = 1'b0;
`endif

   // NOTE: reset here is synchronous, so it appears only inside the clocked
   // branch and never in the sensitivity list.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) state <= IDLE;
      else         state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first so no path leaves
   // a signal unassigned, which would infer a latch.
   always_comb begin
      state_nxt    = state;
      por_rd_en    = 1'b0;
      por_vs_en    = 1'b0;
      por_ee_addr  = 16'h0000;
      por_tc_sel   = 1'b0;
      por_clr_dl   = 1'b0;
      por_cfg_done = 1'b0;
      case (state)
         IDLE:   state_nxt = SETTLE;
         SETTLE: if (settle_last) state_nxt = CLR;
         CLR: begin
            por_clr_dl  = 1'b1;
            por_tc_sel  = 1'b1;
            por_ee_addr = word_addr(BASE_ADDR, word_idx);
            state_nxt   = READ;
         end
         READ: begin
            por_rd_en   = 1'b1;
            por_vs_en   = 1'b1;
            por_tc_sel  = 1'b1;
            por_ee_addr = word_addr(BASE_ADDR, word_idx);
            // The NEXT decision is folded into the last READ cycle, so the
            // state register never actually holds NEXT.
            if (read_last) begin
               if (retry || !last_word) state_nxt = CLR;
               else                     state_nxt = DONE;
            end
         end
         NEXT: state_nxt = CLR;
         DONE: begin
            por_cfg_done = 1'b1;
            if (cfg_reload) state_nxt = CLR;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cnt       <= '0;
         word_idx  <= '0;
         cfg_data  <= '0;
         cfg_err   <= 1'b0;
`ifdef POR_ECC_RETRY_EN
         retry_cnt <= '0;
`endif
      end else begin
         if ((state == SETTLE && !settle_last) || (state == READ && !read_last))
            cnt <= cnt + 1'b1;
         else
            cnt <= '0;

         if (read_last) begin
            if (retry) begin
`ifdef POR_ECC_RETRY_EN
               retry_cnt <= retry_cnt + 1'b1;
`endif
            end else begin
               cfg_data[{word_idx, 5'd0} +: 32] <= ee_rd_data[31:0];
               if (ecc_err) cfg_err <= 1'b1;
               word_idx <= word_idx + 1'b1;
`ifdef POR_ECC_RETRY_EN
               retry_cnt <= '0;
`endif
            end
         end

         if (state == DONE && cfg_reload) begin
            word_idx <= '0;
            cfg_err  <= 1'b0;
`ifdef POR_ECC_RETRY_EN
            retry_cnt <= '0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_por_cfg_module.sv
// Randomized scoreboard bench for por_cfg_module; the expected load outcome
// and address trace come from a word/attempt-level model of the loader.
module tb_por_cfg_module;

   localparam int          SETTLE = 16;
   localparam int          RD     = 4;
   localparam logic [15:0] BASE   = 16'hFFF0;

   typedef struct {
      int           cyc;
      logic [127:0] data;
      logic         err;
      int           cost;
   } exp_t;

   logic         sys_clk = 1'b0;
   logic         sys_rst;
   logic [37:0]  ee_rd_data;
   logic         ecc_err;
   logic         cfg_reload;
   logic         por_rd_en, por_vs_en, por_tc_sel, por_clr_dl, por_cfg_done;
   logic [15:0]  por_ee_addr;
   logic [127:0] cfg_data;
   logic         cfg_err;

   int n_tests = 0;
   int n_fail  = 0;
   int rel_cyc = -1;

   logic [31:0] word_data [4];
   bit          err_pat   [4][3];
   int          att       [4];
   exp_t        exp_q [$];
   logic [15:0] addr_q [$];
   logic [1:0]  ee_w;

   por_cfg_module #(.SETTLE_CYC(SETTLE), .RD_CYC(RD), .BASE_ADDR(BASE)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .ee_rd_data(ee_rd_data),
      .ecc_err(ecc_err), .cfg_reload(cfg_reload), .por_rd_en(por_rd_en),
      .por_vs_en(por_vs_en), .por_ee_addr(por_ee_addr), .por_tc_sel(por_tc_sel),
      .por_clr_dl(por_clr_dl), .por_cfg_done(por_cfg_done),
      .cfg_data(cfg_data), .cfg_err(cfg_err)
   );

   always #5 sys_clk = ~sys_clk;

   // Edge index since reset release: first edge with sys_rst low is 0.
   always @(posedge sys_clk) begin
      if (sys_rst) rel_cyc <= -1;
      else         rel_cyc <= rel_cyc + 1;
   end

   // EEPROM model: word w returns {w, word_data[w]}; error per attempt.
   always_comb begin
      ee_w       = 2'(por_ee_addr - BASE);
      ee_rd_data = {6'(ee_w), word_data[ee_w]};
      ecc_err    = 1'b0;
      if (por_rd_en && att[ee_w] >= 1 && att[ee_w] <= 3)
         ecc_err = err_pat[ee_w][att[ee_w]-1];
   end

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: each word takes (1+RD) cycles per attempt; a failed attempt
   // is retried up to MAX times when retry is enabled.
   task automatic model(input int start);
      exp_t e;
      int   a;
      bit   fail, fin;
      e.data = '0; e.err = 1'b0; e.cost = 0;
      for (int w = 0; w < 4; w++) begin
         a = 0; fin = 0;
         while (!fin) begin
            a++;
            addr_q.push_back(BASE + 16'(w));
            fail = err_pat[w][a-1];
`ifdef POR_ECC_RETRY_EN
            if (!(fail && a <= 2)) fin = 1;
`else
            fin = 1;
`endif
         end
         e.data[w*32 +: 32] = word_data[w];
         e.err  = e.err | fail;
         e.cost = e.cost + a * (RD + 1);
      end
      e.cyc = start + e.cost;
      exp_q.push_back(e);
   endtask

   // Monitor: pops expected address per CLR pulse and expected result per done.
   int          rd_cnt = 0;
   bit          rd_bad = 0;
   logic [15:0] rd_addr;
   int          tc_cnt = 0;
   logic        prev_done = 0;
   exp_t        got;

   always @(negedge sys_clk) begin
      if (rel_cyc < 0 || por_cfg_done) begin
         for (int w = 0; w < 4; w++) att[w] = 0;
      end
      if (rel_cyc < 0) begin
         rd_cnt = 0; rd_bad = 0; tc_cnt = 0; prev_done = 0;
      end else begin
         if (por_clr_dl) begin
            att[2'(por_ee_addr - BASE)]++;
            if (addr_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL clr_unexpected: got addr %h expected no access", por_ee_addr);
            end else begin
               check("clr_addr", 128'(por_ee_addr), 128'(addr_q.pop_front()));
            end
         end
         if (por_rd_en) begin
            if (rd_cnt == 0) rd_addr = por_ee_addr;
            else if (por_ee_addr != rd_addr) rd_bad = 1;
            if (!por_vs_en || !por_tc_sel || por_clr_dl) rd_bad = 1;
            rd_cnt++;
         end else if (rd_cnt != 0) begin
            check("rd_window_len", 128'(rd_cnt), 128'(RD));
            check("rd_window_strobes", 128'(rd_bad), 128'(0));
            rd_cnt = 0; rd_bad = 0;
         end
         if (por_tc_sel) tc_cnt++;
         if (por_cfg_done && !prev_done) begin
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL done_unexpected: got done at cycle %0d expected none", rel_cyc);
            end else begin
               got = exp_q.pop_front();
               check("done_cycle", 128'(rel_cyc), 128'(got.cyc));
               check("cfg_data", cfg_data, got.data);
               check("cfg_err", 128'(cfg_err), 128'(got.err));
               check("tc_sel_cycles", 128'(tc_cnt), 128'(got.cost));
               check("tc_sel_low_in_done", 128'(por_tc_sel), 128'(0));
               check("addr_trace_consumed", 128'(addr_q.size()), 128'(0));
            end
            tc_cnt = 0;
         end
         prev_done = por_cfg_done;
      end
   end

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ctrl"}, 128'({por_rd_en, por_vs_en, por_tc_sel, por_clr_dl,
                                  por_cfg_done, cfg_err}), 128'(0));
      check({tag, "_addr"}, 128'(por_ee_addr), 128'(0));
      check({tag, "_data"}, cfg_data, 128'(0));
   endtask

   task automatic por_load();
      @(negedge sys_clk);
      sys_rst = 1'b1;
      repeat (2) @(negedge sys_clk);
      check_outputs_zero("reset");
      exp_q.delete();
      addr_q.delete();
      model(SETTLE);
      sys_rst = 1'b0;
   endtask

   task automatic wait_sb(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge sys_clk);
         if (exp_q.size() == 0) return;
      end
      n_tests++; n_fail++;
      $display("FAIL done_timeout: got no done in %0d cycles expected done", budget);
      exp_q.delete();
      addr_q.delete();
   endtask

   task automatic set_words(input bit rnd);
      for (int w = 0; w < 4; w++) begin
         word_data[w] = rnd ? $urandom : 32'h1111_1111;
         for (int a = 0; a < 3; a++) err_pat[w][a] = 0;
      end
   endtask

   task automatic reload(input bit rnd_err);
      set_words(1);
      if (rnd_err)
         for (int w = 0; w < 4; w++)
            for (int a = 0; a < 3; a++) err_pat[w][a] = ($urandom_range(0, 3) == 0);
      model(rel_cyc + 1);
      cfg_reload = 1'b1;
      @(negedge sys_clk);
      cfg_reload = 1'b0;
      check("reload_done_drop", 128'(por_cfg_done), 128'(0));
   endtask

   initial begin
      sys_rst    = 1'b1;
      cfg_reload = 1'b0;
      set_words(0);

      // Spec data pattern, no ECC errors.
      por_load();
      wait_sb(200);

      // ECC error on word 1 first read only.
      set_words(1);
      err_pat[1][0] = 1;
      por_load();
      wait_sb(200);

      // ECC error on every read of word 2.
      set_words(1);
      for (int a = 0; a < 3; a++) err_pat[2][a] = 1;
      por_load();
      wait_sb(200);

      // Random data and random error patterns.
      for (int k = 0; k < 3; k++) begin
         set_words(1);
         for (int w = 0; w < 4; w++)
            for (int a = 0; a < 3; a++) err_pat[w][a] = ($urandom_range(0, 3) == 0);
         por_load();
         wait_sb(200);
      end

      // Reload in SETTLE is ignored; reloads in DONE clear cfg_err and refetch.
      set_words(1);
      for (int a = 0; a < 3; a++) err_pat[0][a] = 1;
      por_load();
      repeat (4) @(negedge sys_clk);
      cfg_reload = 1'b1;
      @(negedge sys_clk);
      cfg_reload = 1'b0;
      wait_sb(200);
      @(negedge sys_clk);
      reload(0);
      wait_sb(200);
      repeat (3) @(negedge sys_clk);
      reload(1);
      wait_sb(200);

      // Reset pulse during the word 2 read window.
      set_words(1);
      por_load();
      for (int i = 0; i < 200; i++) begin
         @(negedge sys_clk);
         if (por_rd_en && por_ee_addr == BASE + 16'd2) break;
      end
      check("reached_word2_read", 128'(por_rd_en && por_ee_addr == BASE + 16'd2), 128'(1));
      sys_rst = 1'b1;
      @(negedge sys_clk);
      check_outputs_zero("midread_reset");
      set_words(1);
      por_load();
      wait_sb(200);

      repeat (3) @(negedge sys_clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
